// File: rtl/power_k_norm.sv
`default_nettype none
// ============================================================================
// Module   : power_k_norm
// Brief    : Two-stage leading-one normalizer that emits the index K of the
//            most significant one and a WIDTH-bit mantissa aligned to it.
//            Optional macro POWER_K_NORM_ROUND_EN enables half-up rounding.
// Revision : 1.0  initial release
// ============================================================================
module power_k_norm #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [2*WIDTH-1:0]    DIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [LOG2_WIDTH:0]   K_OUT,
  output logic [WIDTH-1:0]      MANT,
  output logic                  ZERO
);

  localparam int DW = 2 * WIDTH;
  localparam int KW = LOG2_WIDTH + 1;
  localparam logic [KW-1:0] K_ALIGN = KW'(WIDTH - 1);
`ifdef POWER_K_NORM_ROUND_EN
  localparam logic [KW-1:0] K_TOP   = KW'(DW - 1);
`endif

  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic [KW-1:0] s1_k;
  logic          s1_zero;

  logic          s2_load;
  logic          in_ready;
  logic [KW-1:0] enc_k;
  logic [KW-1:0] s2_k;
  logic [WIDTH-1:0] s2_mant;
  logic [KW-1:0] rsh;
  logic [KW-1:0] lsh;
`ifdef POWER_K_NORM_ROUND_EN
  logic          round_bit;
  logic [WIDTH:0] round_sum;
`endif

  // The output register frees up whenever it is empty or being consumed;
  // the same condition lets S1 hand its word forward.
  assign s2_load  = !OUT_VALID || OUT_READY;
  assign in_ready = !s1_valid || s2_load;
  assign IN_READY = in_ready;

  always_comb begin
    enc_k = '0;
    for (int i = 0; i < DW; i++) begin
      if (DIN[i]) enc_k = KW'(i);
    end
  end

  always_comb begin
    s2_k    = s1_k;
    s2_mant = '0;
    rsh     = s1_k - K_ALIGN;
    lsh     = K_ALIGN - s1_k;
    if (s1_zero) begin
      s2_k    = '0;
      s2_mant = '0;
    end else if (s1_k >= K_ALIGN) begin
      s2_mant = WIDTH'(s1_data >> rsh);
    end else begin
      s2_mant = WIDTH'(s1_data << lsh);
    end
`ifdef POWER_K_NORM_ROUND_EN
    round_bit = 1'b0;
    round_sum = '0;
    if (!s1_zero && (s1_k > K_ALIGN)) begin
      round_bit = |(s1_data & (DW'(1) << (rsh - KW'(1))));
      round_sum = {1'b0, s2_mant} + (WIDTH+1)'(round_bit);
      if (round_sum[WIDTH]) begin
        // Carry out of the mantissa renormalizes, except at the top index.
        if (s1_k == K_TOP) begin
          s2_mant = '1;
        end else begin
          s2_mant = {1'b1, {(WIDTH-1){1'b0}}};
          s2_k    = s1_k + KW'(1);
        end
      end else begin
        s2_mant = round_sum[WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_k      <= '0;
      s1_zero   <= 1'b0;
      OUT_VALID <= 1'b0;
      K_OUT     <= '0;
      MANT      <= '0;
      ZERO      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= IN_VALID;
        if (IN_VALID) begin
          s1_data <= DIN;
          s1_k    <= enc_k;
          s1_zero <= (DIN == '0);
        end
      end
      if (s2_load) begin
        OUT_VALID <= s1_valid;
        if (s1_valid) begin
          K_OUT <= s2_k;
          MANT  <= s2_mant;
          ZERO  <= s1_zero;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_power_k_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_k_norm
// Brief    : Self-checking bench for power_k_norm with a scoreboard model.
// Revision : 1.0  initial release
// ============================================================================
module tb_power_k_norm;

  typedef struct {
    int unsigned k;
    int unsigned mant;
    bit          zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] DIN = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [4:0]  K_OUT;
  logic [15:0] MANT;
  logic        ZERO;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  int   delivered = 0;
  int unsigned last_k = 0;
  int unsigned last_mant = 0;
  int unsigned last_zero = 0;

  power_k_norm #(.WIDTH(16), .LOG2_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .DIN(DIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .K_OUT(K_OUT), .MANT(MANT), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: leading-one index by counting, mantissa by scaling.
  function automatic res_t model(input logic [31:0] d);
    res_t r;
    longint unsigned v = d;
    longint unsigned scale;
    int k = 0;
    if (v == 0) begin
      r.k = 0; r.mant = 0; r.zero = 1;
      return r;
    end
    while ((v >> (k + 1)) != 0) k++;
    r.zero = 0;
    r.k = k;
    if (k >= 15) begin
      scale  = longint'(1) << (k - 15);
      r.mant = int'(v / scale);
`ifdef POWER_K_NORM_ROUND_EN
      if (k >= 16 && (v % scale) * 2 >= scale) begin
        r.mant++;
        if (r.mant == 65536) begin
          if (k == 31) r.mant = 65535;
          else begin r.mant = 32768; r.k = k + 1; end
        end
      end
`endif
    end else begin
      r.mant = int'(v * (longint'(1) << (15 - k)));
    end
    return r;
  endfunction

  // One clock cycle: apply inputs, score any transfers, advance past the edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, output bit acc);
    res_t e;
    IN_VALID = iv; DIN = d; OUT_READY = ordy;
    #1;
    acc = IN_VALID && IN_READY;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("k_out", K_OUT, e.k);
        check("mant", MANT, e.mant);
        check("zero", ZERO, e.zero);
        last_k = K_OUT; last_mant = MANT; last_zero = ZERO;
        delivered++;
      end
    end
    if (acc) exp_q.push_back(model(d));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] d);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 20) begin step(1'b1, d, 1'b1, acc); n++; end
    if (!acc) check("send_timeout", 0, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(1'b0, '0, 1'b1, acc); n++; end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int accepted;
    int n;
    logic [4:0]  hold_k;
    logic [15:0] hold_m;
    logic [31:0] words[4];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_k", K_OUT, 0);
    check("rst_mant", MANT, 0);
    check("rst_zero", ZERO, 0);

    // Latency: accepted in cycle n, visible in cycle n+2.
    step(1'b1, 32'h0000_0001, 1'b1, acc);
    check("lat_accept", acc, 1);
    check("lat_n1", OUT_VALID, 0);
    step(1'b0, '0, 1'b0, acc);
    check("lat_n2", OUT_VALID, 1);
    step(1'b0, '0, 1'b1, acc);
    check("d1_k", last_k, 0);
    check("d1_mant", last_mant, 16'h8000);
    check("d1_zero", last_zero, 0);

    send_one(32'h8000_0000);
    check("d2_k", last_k, 31);
    check("d2_mant", last_mant, 16'h8000);
    send_one(32'h0001_8001);
    check("d3_k", last_k, 16);
`ifdef POWER_K_NORM_ROUND_EN
    check("d3_mant", last_mant, 16'hC001);
`else
    check("d3_mant", last_mant, 16'hC000);
`endif
    send_one(32'h0000_0000);
    check("d4_zero", last_zero, 1);
    check("d4_k", last_k, 0);
    check("d4_mant", last_mant, 0);
    send_one(32'h0001_FFFF);
`ifdef POWER_K_NORM_ROUND_EN
    check("d5_k", last_k, 17);
    check("d5_mant", last_mant, 16'h8000);
`else
    check("d5_k", last_k, 16);
    check("d5_mant", last_mant, 16'hFFFF);
`endif
    send_one(32'hFFFF_FFFF);
    check("d6_k", last_k, 31);
    check("d6_mant", last_mant, 16'hFFFF);

    // Backpressure: four words offered with the sink stalled for 5 cycles.
    words[0] = 32'h0000_00F0; words[1] = 32'h1234_5678;
    words[2] = 32'h0000_0003; words[3] = 32'h0040_0001;
    accepted = 0;
    delivered = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, words[accepted], 1'b0, acc);
      if (acc) accepted++;
      if (c == 2) begin hold_k = K_OUT; hold_m = MANT; end
      if (c > 2) begin
        check("bp_hold_k", K_OUT, hold_k);
        check("bp_hold_mant", MANT, hold_m);
      end
    end
    check("bp_accepted", accepted, 2);
    OUT_READY = 1'b0; #1;
    check("bp_in_ready", IN_READY, 0);
    check("bp_out_valid", OUT_VALID, 1);
    n = 0;
    while ((accepted < 4 || exp_q.size() != 0) && n < 40) begin
      step(accepted < 4, words[accepted < 4 ? accepted : 0], 1'b1, acc);
      if (acc) accepted++;
      n++;
    end
    check("bp_delivered", delivered, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // Random streaming with random backpressure.
    accepted = 0;
    n = 0;
    while (accepted < 100 && n < 2000) begin
      logic [31:0] d;
      d = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, acc);
      if (acc) accepted++;
      n++;
    end
    check("stream_accepted", accepted, 100);

    // Fill the pipe, then reset mid-flight.
    for (int c = 0; c < 3; c++) step(1'b1, $urandom | 32'h1, 1'b0, acc);
    check("full_out_valid", OUT_VALID, 1);
    rst = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_k", K_OUT, 0);
    check("mid_rst_mant", MANT, 0);
    check("mid_rst_zero", ZERO, 0);
    rst = 1'b0; #1;
    check("mid_rst_in_ready", IN_READY, 1);
    @(posedge clk); #1;
    check("post_rst_out_valid", OUT_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
